// File: rtl/barrel_shift_arbiter.sv
// Shares one registered barrel shifter between the alignment (right shift)
// and normalization (left shift) requesters of the FP add/sub datapath.
// Issues one operation at a time, waits out the shifter latency and returns
// the tagged result together with an alignment sticky bit.
module barrel_shift_arbiter #(
   parameter int unsigned SWR = 26,
   parameter int unsigned EWR = 5,
   parameter int unsigned LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           align_req_i,
   input  logic [SWR-1:0] align_data_i,
   input  logic [EWR-1:0] align_amt_i,
   output logic           align_gnt_o,
   input  logic           norm_req_i,
   input  logic [SWR-1:0] norm_data_i,
   input  logic [EWR-1:0] norm_amt_i,
   output logic           norm_gnt_o,
   output logic           bs_load_o,
   output logic [EWR-1:0] bs_shift_value_o,
   output logic [SWR-1:0] bs_shift_data_o,
   output logic           bs_left_right_o,
   output logic           bs_bit_shift_o,
   input  logic [SWR-1:0] bs_data_i,
   output logic           res_valid_o,
   output logic           res_owner_o,
   output logic [SWR-1:0] res_data_o,
   output logic           res_sticky_o,
   output logic           busy_o
);

   localparam int unsigned CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic           last_owner;
   logic           owner;
   logic [SWR-1:0] op_data;
   logic [EWR-1:0] op_amt;
   logic           sel_norm;
   logic           take;
   logic           sticky;

   // Round-robin selection and capture decision; only IDLE/DONE may accept.
   always_comb begin
      sel_norm = norm_req_i & (~align_req_i | ~last_owner);
      take     = ((state == IDLE) || (state == DONE)) && (align_req_i || norm_req_i);
   end

   // Next-state logic for the issue/wait/done sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (cnt == CW'(1)) state_nxt = DONE;
         DONE:    state_nxt = take ? ISSUE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Sticky of an alignment: OR of every operand bit below the shift amount.
   // Amounts at or beyond SWR naturally cover the whole operand.
   always_comb begin
      sticky = 1'b0;
      if (!owner) begin
         for (int unsigned i = 0; i < SWR; i++) begin
            if (i < 32'(op_amt)) sticky = sticky | op_data[i];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Operand capture and round-robin history, updated when a request is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner      <= 1'b0;
         last_owner <= 1'b1;
         op_data    <= '0;
         op_amt     <= '0;
      end else if (take) begin
         owner      <= sel_norm;
         last_owner <= sel_norm;
         op_data    <= sel_norm ? norm_data_i : align_data_i;
         op_amt     <= sel_norm ? norm_amt_i  : align_amt_i;
      end
   end

   // Latency counter: loaded while issuing, counts down through WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 cnt <= '0;
      else if (state == ISSUE) cnt <= CW'(LAT);
      else if (state == WAIT)  cnt <= cnt - CW'(1);
   end

   // Result capture on the last WAIT cycle; held until the next result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_data_o   <= '0;
         res_sticky_o <= 1'b0;
      end else if ((state == WAIT) && (cnt == CW'(1))) begin
         res_data_o   <= bs_data_i;
         res_sticky_o <= sticky;
      end
   end

   // Decoded outputs.
   always_comb begin
      align_gnt_o      = (state == ISSUE) & ~owner;
      norm_gnt_o       = (state == ISSUE) & owner;
      bs_load_o        = (state == ISSUE);
      bs_shift_value_o = op_amt;
      bs_shift_data_o  = op_data;
      bs_left_right_o  = owner;
      bs_bit_shift_o   = 1'b0;
      res_valid_o      = (state == DONE);
      res_owner_o      = (state == DONE) & owner;
      busy_o           = (state != IDLE);
   end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Testbench for barrel_shift_arbiter with a behavioural one-cycle shifter.
module tb_barrel_shift_arbiter;

   localparam int unsigned SWR = 26;
   localparam int unsigned EWR = 5;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           align_req = 1'b0;
   logic [SWR-1:0] align_data = '0;
   logic [EWR-1:0] align_amt = '0;
   logic           align_gnt;
   logic           norm_req = 1'b0;
   logic [SWR-1:0] norm_data = '0;
   logic [EWR-1:0] norm_amt = '0;
   logic           norm_gnt;
   logic           bs_load;
   logic [EWR-1:0] bs_shift_value;
   logic [SWR-1:0] bs_shift_data;
   logic           bs_left_right;
   logic           bs_bit_shift;
   logic [SWR-1:0] bs_data = '0;
   logic           res_valid;
   logic           res_owner;
   logic [SWR-1:0] res_data;
   logic           res_sticky;
   logic           busy;

   barrel_shift_arbiter #(.SWR(SWR), .EWR(EWR), .LAT(1)) dut (
      .clk(clk), .rst(rst),
      .align_req_i(align_req), .align_data_i(align_data), .align_amt_i(align_amt),
      .align_gnt_o(align_gnt),
      .norm_req_i(norm_req), .norm_data_i(norm_data), .norm_amt_i(norm_amt),
      .norm_gnt_o(norm_gnt),
      .bs_load_o(bs_load), .bs_shift_value_o(bs_shift_value), .bs_shift_data_o(bs_shift_data),
      .bs_left_right_o(bs_left_right), .bs_bit_shift_o(bs_bit_shift), .bs_data_i(bs_data),
      .res_valid_o(res_valid), .res_owner_o(res_owner), .res_data_o(res_data),
      .res_sticky_o(res_sticky), .busy_o(busy)
   );

   always #5 clk = ~clk;

   // Behavioural Barrel_Shifter, latency 1, zero fill.
   always @(posedge clk)
      if (bs_load)
         bs_data <= bs_left_right ? (bs_shift_data << bs_shift_value)
                                  : (bs_shift_data >> bs_shift_value);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [SWR-1:0] d; logic [EWR-1:0] a; } op_t;
   typedef struct { logic own; logic [SWR-1:0] d; logic st; } exp_t;

   op_t  aq[$];
   op_t  nq[$];
   exp_t sb[$];
   bit   gq[$];
   bit   model_last = 1'b1;
   bit   b2b = 1'b0;
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on a 64-bit copy of the operand.
   function automatic exp_t model(input bit own, input op_t o);
      exp_t e;
      longint unsigned d, mask, kept;
      d    = 64'(o.d);
      mask = (64'd1 << SWR) - 64'd1;
      e.own = own;
      if (own) begin
         e.d  = SWR'((d << o.a) & mask);
         e.st = 1'b0;
      end else begin
         kept = (d >> o.a) << o.a;
         e.d  = SWR'(d >> o.a);
         e.st = (kept != d);
      end
      return e;
   endfunction

   function automatic logic outputs_nonzero();
      return |{align_gnt, norm_gnt, bs_load, bs_shift_value, bs_shift_data, bs_left_right,
               bs_bit_shift, res_valid, res_owner, res_data, res_sticky, busy};
   endfunction

   // Monitor: grants against the predicted order, results against the scoreboard.
   initial begin
      exp_t e;
      bit   g;
      bit   prev_gnt;
      int   last_gc;
      prev_gnt = 1'b0;
      last_gc  = -1;
      forever begin
         @(negedge clk);
         if (align_gnt && norm_gnt) chk("dual_gnt", 1, 0);
         if (align_gnt || norm_gnt) begin
            chk("gnt_one_pulse", 64'(prev_gnt), 0);
            chk("gnt_load", 64'(bs_load), 1);
            chk("gnt_dir", 64'(bs_left_right), 64'(norm_gnt));
            if (gq.size() == 0) chk("gnt_unexpected", 1, 0);
            else begin
               g = gq.pop_front();
               chk("gnt_owner", 64'(norm_gnt), 64'(g));
            end
            if (b2b && last_gc >= 0) chk("gnt_spacing", 64'(cyc - last_gc), 3);
            last_gc = b2b ? cyc : -1;
         end
         if (!b2b) last_gc = -1;
         prev_gnt = align_gnt | norm_gnt;
         if (res_valid) begin
            if (sb.size() == 0) chk("res_unexpected", 1, 0);
            else begin
               e = sb.pop_front();
               chk("res_owner", 64'(res_owner), 64'(e.own));
               chk("res_data", 64'(res_data), 64'(e.d));
               chk("res_sticky", 64'(res_sticky), 64'(e.st));
            end
         end
      end
   end

   // Predicts the round-robin service order of everything queued, then keeps
   // each requester's req high while it has operations left.
   task automatic run_queues(input int budget);
      int  ia, in, n;
      bit  ml, pick;
      ia = 0; in = 0; ml = model_last;
      while (ia < aq.size() || in < nq.size()) begin
         if (ia < aq.size() && in < nq.size()) pick = ~ml;
         else pick = (in < nq.size());
         gq.push_back(pick);
         if (pick) begin sb.push_back(model(1'b1, nq[in])); in++; end
         else      begin sb.push_back(model(1'b0, aq[ia])); ia++; end
         ml = pick;
      end
      model_last = ml;
      align_req = (aq.size() != 0);
      if (align_req) begin align_data = aq[0].d; align_amt = aq[0].a; end
      norm_req = (nq.size() != 0);
      if (norm_req) begin norm_data = nq[0].d; norm_amt = nq[0].a; end
      n = 0;
      while (aq.size() != 0 || nq.size() != 0 || sb.size() != 0 || gq.size() != 0) begin
         @(negedge clk);
         n++;
         if (align_gnt && aq.size() != 0) begin
            void'(aq.pop_front());
            align_req = (aq.size() != 0);
            if (align_req) begin align_data = aq[0].d; align_amt = aq[0].a; end
         end
         if (norm_gnt && nq.size() != 0) begin
            void'(nq.pop_front());
            norm_req = (nq.size() != 0);
            if (norm_req) begin norm_data = nq[0].d; norm_amt = nq[0].a; end
         end
         if (n > budget) begin
            chk("timeout", 64'(n), 64'(budget));
            aq.delete(); nq.delete(); sb.delete(); gq.delete();
            align_req = 1'b0; norm_req = 1'b0;
         end
      end
      align_req = 1'b0;
      norm_req  = 1'b0;
   endtask

   initial begin
      op_t o;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'(outputs_nonzero()), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_outputs", 64'(outputs_nonzero()), 0);

      // Align only, with exact cycle timing.
      o.d = 26'h2000003; o.a = 5'd2;
      sb.push_back(model(1'b0, o)); gq.push_back(1'b0);
      align_req = 1'b1; align_data = o.d; align_amt = o.a;
      @(negedge clk);
      chk("align_gnt_cycle2", 64'(align_gnt), 1);
      align_req = 1'b0;
      @(negedge clk);
      chk("align_wait_busy", 64'({busy, res_valid}), 64'(2'b10));
      @(negedge clk);
      chk("align_valid_cycle4", 64'(res_valid), 1);
      chk("align_res_literal", 64'(res_data), 64'(26'h0800000));
      @(negedge clk);
      chk("align_idle_after", 64'(busy), 0);
      model_last = 1'b0;

      // Norm only.
      o.d = 26'h0000100; o.a = 5'd17;
      sb.push_back(model(1'b1, o)); gq.push_back(1'b1);
      norm_req = 1'b1; norm_data = o.d; norm_amt = o.a;
      @(negedge clk);
      chk("norm_gnt", 64'(norm_gnt), 1);
      chk("norm_dir_issue", 64'(bs_left_right), 1);
      norm_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("norm_valid", 64'(res_valid), 1);
      chk("norm_res_literal", 64'(res_data), 64'(26'h2000000));
      @(negedge clk);
      model_last = 1'b1;

      // Reset in the middle of WAIT drops the operation.
      gq.push_back(1'b0);
      align_req = 1'b1; align_data = 26'h1234567; align_amt = 5'd3;
      @(negedge clk);
      align_req = 1'b0;
      @(negedge clk);
      chk("pre_reset_busy", 64'(busy), 1);
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("midop_reset_outputs", 64'(outputs_nonzero()), 0);
      end
      rst = 1'b0;
      model_last = 1'b1;
      @(negedge clk);
      chk("post_reset_outputs", 64'(outputs_nonzero()), 0);
      o.d = 26'h00000F0; o.a = 5'd5; aq.push_back(o);
      run_queues(50);

      // Amount boundaries.
      o.d = 26'h0000001; o.a = 5'd31; aq.push_back(o);
      o.d = 26'h3FFFFFF; o.a = 5'd0;  aq.push_back(o);
      run_queues(50);
      @(negedge clk);

      // Both requesting: alternation and back-to-back spacing.
      for (int i = 0; i < 2; i++) begin
         o.d = SWR'($urandom); o.a = EWR'($urandom); aq.push_back(o);
         o.d = SWR'($urandom); o.a = EWR'($urandom); nq.push_back(o);
      end
      b2b = 1'b1;
      run_queues(100);
      b2b = 1'b0;
      @(negedge clk);

      // Full amount sweep in both directions on random data.
      for (int unsigned a = 0; a < 32; a++) begin
         o.d = SWR'($urandom); o.a = EWR'(a); aq.push_back(o);
         o.d = SWR'($urandom); o.a = EWR'(a); nq.push_back(o);
      end
      b2b = 1'b1;
      run_queues(400);
      b2b = 1'b0;
      @(negedge clk);

      // Random uneven mix.
      for (int i = 0; i < 20; i++) begin
         o.d = SWR'($urandom); o.a = EWR'($urandom_range(0, 31));
         if ($urandom_range(0, 2) != 0) aq.push_back(o);
         else nq.push_back(o);
      end
      run_queues(300);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", 64'(sb.size() + gq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
